// File: rtl/demux_scan_ctrl_pkg.sv
// Shared types and constants for the demux scan controller.
package demux_scan_ctrl_pkg;

  localparam int unsigned NCH  = 4;
  localparam int unsigned SelW = $clog2(NCH);

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StDwell = 2'd1;
  localparam state_t StDone  = 2'd2;

  // Lowest enabled channel; callers guarantee a non-zero mask.
  function automatic logic [SelW-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (m[k]) lowest_set = SelW'(k);
    end
  endfunction

endpackage

// File: rtl/demux_scan_ctrl_if.sv
// Control, data and demux-side signals of the scan controller.
interface demux_scan_ctrl_if #(
  parameter int unsigned DWELL_W = 4
);
  import demux_scan_ctrl_pkg::*;

  logic               start;
  logic               stop;
  logic               mode;
  logic [NCH-1:0]     mask;
  logic [DWELL_W-1:0] dwell;
  logic               data_in;
  logic               en;
  logic [SelW-1:0]    sel;
  logic               in;
  logic               busy;
  logic               ch_tick;
  logic               done;

  modport master (
    output start, stop, mode, mask, dwell, data_in,
    input  en, sel, in, busy, ch_tick, done
  );

  modport slave (
    input  start, stop, mode, mask, dwell, data_in,
    output en, sel, in, busy, ch_tick, done
  );

endinterface

// File: rtl/demux_scan_ctrl_mask_next_sel.sv
// Next enabled channel above the current one (circular) and wrap flag.
module mask_next_sel
  import demux_scan_ctrl_pkg::*;
(
  input  logic [SelW-1:0] sel_i,
  input  logic [NCH-1:0]  mask_i,
  output logic [SelW-1:0] next_sel_o,
  output logic            wrap_o
);

  logic            found;
  logic [SelW-1:0] cand;

  // Search sel+1 .. sel+NCH; the final candidate is sel itself (single-bit mask).
  always_comb begin
    next_sel_o = sel_i;
    found      = 1'b0;
    cand       = sel_i;
    for (int k = 1; k <= NCH; k++) begin
      cand = sel_i + SelW'(k);
      if (!found && mask_i[cand]) begin
        next_sel_o = cand;
        found      = 1'b1;
      end
    end
    wrap_o = (next_sel_o <= sel_i);
  end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Scans the enabled demux channels, dwelling dwell+1 cycles on each.
module demux_scan_ctrl
  import demux_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  demux_scan_ctrl_if.slave  bus
);

  state_t             state_q, state_d;
  logic [SelW-1:0]    sel_q, sel_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               in_q, en_q, busy_q, tick_q, done_q;
  logic [SelW-1:0]    next_sel;
  logic               wrap;

  mask_next_sel u_next_sel (
    .sel_i      (sel_q),
    .mask_i     (mask_q),
    .next_sel_o (next_sel),
    .wrap_o     (wrap)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stop) begin
          mode_d  = bus.mode;
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          if (bus.mask != '0) begin
            state_d = StDwell;
            sel_d   = lowest_set(bus.mask);
            cnt_d   = bus.dwell;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDwell: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (wrap && mode_q) begin
          state_d = StDone;
        end else begin
          sel_d = next_sel;
          cnt_d = dwell_q;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      mask_q  <= '0;
      dwell_q <= '0;
      in_q    <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      in_q    <= bus.data_in;
      en_q    <= (state_d == StDwell);
      busy_q  <= (state_d == StDwell);
      tick_q  <= (state_d == StDwell) && (cnt_d == '0);
      done_q  <= (state_d == StDone);
    end
  end

  assign bus.en      = en_q;
  assign bus.sel     = sel_q;
  assign bus.in      = in_q;
  assign bus.busy    = busy_q;
  assign bus.ch_tick = tick_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Scoreboard bench: a channel-list model queues expected cycles, a monitor pops them.
module tb_demux_scan_ctrl;

  localparam int unsigned DW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_scan_ctrl_if #(.DWELL_W(DW)) dif ();

  demux_scan_ctrl #(.DWELL_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  typedef struct packed {
    logic       done;
    logic [1:0] sel;
    logic       tick;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         en_cnt = 0;
  logic       din_prev = 1'b0;
  logic [1:0] last_sel = 2'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) din_prev <= dif.data_in;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dif.en || dif.done) begin
        if (dif.en) en_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {30'd0, dif.en, dif.done}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.done) begin
            chk("done", dif.done, 1);
            chk("done_en", dif.en, 0);
            chk("done_tick", dif.ch_tick, 0);
          end else begin
            chk("en", dif.en, 1);
            chk("done_in_dwell", dif.done, 0);
            chk("busy", dif.busy, 1);
            chk("sel", dif.sel, mon_e.sel);
            chk("ch_tick", dif.ch_tick, mon_e.tick);
            chk("in", dif.in, din_prev);
            last_sel = mon_e.sel;
          end
        end
      end else begin
        chk("idle_busy", dif.busy, 0);
        chk("idle_tick", dif.ch_tick, 0);
        chk("idle_sel", dif.sel, last_sel);
      end
    end
  end

  // Model: enabled channels in ascending order, each held dwell+1 cycles.
  task automatic expect_scan(input logic mode, input logic [3:0] mask, input int dwell,
                             input int stop_at, output int len, output bit stopped);
    int   chans[$];
    int   n;
    int   total;
    exp_t e;
    for (int k = 0; k < 4; k++) if (mask[k]) chans.push_back(k);
    n = chans.size();
    if (n == 0) begin
      len     = 0;
      stopped = 1'b0;
      e       = '0;
      e.done  = 1'b1;
      exp_q.push_back(e);
      return;
    end
    total   = mode ? n * (dwell + 1) : 32'h3fff_ffff;
    stopped = (stop_at > 0) && (stop_at <= total);
    len     = stopped ? stop_at : total;
    for (int i = 0; i < len; i++) begin
      e.done = 1'b0;
      e.sel  = 2'(chans[(i / (dwell + 1)) % n]);
      e.tick = ((i % (dwell + 1)) == dwell);
      exp_q.push_back(e);
    end
    if (!stopped) begin
      e      = '0;
      e.done = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Stray starts and config changes are injected while the scan runs.
  task automatic run_scan(input logic mode, input logic [3:0] mask, input int dwell,
                          input int stop_at);
    int len;
    bit stopped;
    expect_scan(mode, mask, dwell, stop_at, len, stopped);
    en_cnt = 0;
    @(posedge clk); #1;
    dif.start   = 1'b1;
    dif.mode    = mode;
    dif.mask    = mask;
    dif.dwell   = DW'(dwell);
    dif.data_in = 1'($urandom);
    for (int j = 1; j <= len + 3; j++) begin
      @(posedge clk); #1;
      dif.data_in = 1'($urandom);
      dif.mode    = 1'($urandom);
      dif.mask    = 4'($urandom);
      dif.dwell   = DW'($urandom);
      dif.start   = (j <= len - 1) && ($urandom_range(0, 2) == 0);
      dif.stop    = stopped && (j == stop_at);
    end
    dif.start = 1'b0;
    dif.stop  = 1'b0;
    for (int w = 0; w < 30 && exp_q.size() != 0; w++) @(posedge clk);
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk); #1;
    chk("en_count", en_cnt, len);
    chk("idle_after_scan", dif.en, 0);
  endtask

  initial begin
    int len;
    bit stopped;
    rst_n       = 1'b1;
    dif.start   = 1'b0;
    dif.stop    = 1'b0;
    dif.mode    = 1'b0;
    dif.mask    = '0;
    dif.dwell   = '0;
    dif.data_in = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("rst_en", dif.en, 0);
    chk("rst_sel", dif.sel, 0);
    chk("rst_in", dif.in, 0);
    chk("rst_busy", dif.busy, 0);
    chk("rst_tick", dif.ch_tick, 0);
    chk("rst_done", dif.done, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_scan(1'b1, 4'b1111, 2, 0);
    run_scan(1'b1, 4'b1010, 0, 0);
    run_scan(1'b0, 4'b0101, 1, 7);
    run_scan(1'b1, 4'b0000, 3, 0);
    run_scan(1'b1, 4'b0100, 2, 0);
    run_scan(1'b0, 4'b1000, 0, 5);

    // Reset during a scan: outputs clear at once and no done follows.
    expect_scan(1'b1, 4'b1111, 5, 0, len, stopped);
    @(posedge clk); #1;
    dif.start = 1'b1; dif.mode = 1'b1; dif.mask = 4'b1111; dif.dwell = DW'(5);
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      dif.start   = (j == 2);
      dif.data_in = 1'($urandom);
    end
    dif.start = 1'b0;
    #2 rst_n = 1'b0;
    last_sel = 2'd0;
    #1;
    chk("midrst_en", dif.en, 0);
    chk("midrst_sel", dif.sel, 0);
    chk("midrst_in", dif.in, 0);
    chk("midrst_busy", dif.busy, 0);
    chk("midrst_tick", dif.ch_tick, 0);
    chk("midrst_done", dif.done, 0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("post_rst_idle", dif.en, 0);

    for (int r = 0; r < 25; r++) begin
      logic       m;
      logic [3:0] mk;
      int         dw;
      int         sa;
      m  = 1'($urandom);
      mk = 4'($urandom);
      dw = $urandom_range(0, 3);
      if (!m) sa = $urandom_range(1, 30);
      else    sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      run_scan(m, mk, dw, sa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_scan_ctrl.md
DEMUX_SCAN_CTRL -- requirements
Module: demux_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, 4, width of the per-channel dwell count.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-003 Port list SHALL be as follows:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a scan; sampled only in IDLE.
- stop, input, 1: abort the scan; takes priority over start.
- mode, input, 1: 0 = continuous auto-scan, 1 = single pass; sampled at start.
- mask, input, 4: channel enable bitmap; bit k enables channel k; sampled at start.
- dwell, input, DWELL_W: cycles per channel minus one; sampled at start.
- data_in, input, 1: serial data to route.
- en, output, 1: demux enable.
- sel, output, 2: demux channel select.
- in, output, 1: registered data_in, fed to the demux.
- busy, output, 1: high in DWELL.
- ch_tick, output, 1: one-cycle pulse on the last cycle of each channel dwell.
- done, output, 1: one-cycle pulse when a scan ends.

Function
REQ-004 The FSM SHALL have three states: IDLE, DWELL and DONE.
REQ-005 IDLE SHALL drive en=0 and busy=0, and SHALL hold sel at its last value.
REQ-006 In IDLE, start=1 with mask!=0 SHALL latch mode, mask and dwell, set sel to the lowest set mask bit, load the counter with dwell, and enter DWELL on the next cycle.
REQ-007 In IDLE, start=1 with mask==0 SHALL enter DONE directly, and en SHALL never be asserted.
REQ-008 In DWELL, the block SHALL drive en=1 and busy=1, and in SHALL equal data_in delayed by one clock.
REQ-009 Timing: start seen at edge t SHALL give en=1 from edge t+1; each channel SHALL be held for exactly dwell+1 cycles.
REQ-010 In DWELL, the counter SHALL decrement every cycle; when it reaches 0, ch_tick SHALL be 1, and the next cycle SHALL switch sel to the next set bit of the latched mask above the current sel, wrapping 3->0, and reload the counter.
REQ-011 Wrap detection SHALL apply when the next set bit is less than or equal to the current sel: mode=1 SHALL enter DONE; mode=0 SHALL continue scanning.
REQ-012 With a single set mask bit, the block SHALL stay on that channel; each dwell expiry counts as a wrap.
REQ-013 DONE SHALL last exactly one cycle with done=1 and en=0, then return to IDLE.
REQ-014 stop=1 in DWELL SHALL force IDLE on the next edge, with no done pulse and no ch_tick on that cycle.
REQ-015 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-016 Changes to mask, dwell or mode during a scan SHALL have no effect until the next start.
REQ-017 dwell=0 SHALL produce one cycle per channel, with ch_tick high on every DWELL cycle.
REQ-018 Every output SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-019 rst_n=0 SHALL immediately force IDLE, en=0, sel=0, in=0, busy=0, ch_tick=0, done=0, counter=0 and all latched fields to 0.
REQ-020 Reset asserted mid-scan SHALL abort with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-021 A shared package SHALL hold the state enum (IDLE/DWELL/DONE) and the channel count constant NCH=4.
REQ-022 A single sub-module, mask_next_sel, SHALL compute the next set mask bit and the wrap flag from the current sel and mask, combinationally.
REQ-023 The block SHALL drive the existing 1-to-4 demux (en/sel/in) directly, with the demux HL input tied externally.

Verification
REQ-024 Directed scenario coverage:
- Single pass: mode=1, mask=4'b1111, dwell=2, start pulse → sel 0,1,2,3 each for 3 cycles; 4 ch_tick pulses; done one cycle after the last tick; en high for exactly 12 cycles.
- Sparse mask: mode=1, mask=4'b1010, dwell=0 → sel 1 then 3, one cycle each; done follows.
- Continuous with abort: mode=0, mask=4'b0101, dwell=1 → sel 0,0,2,2,0,0,...; stop after 7 DWELL cycles → en=0 next cycle; no done.
- Empty mask: mode=1, mask=4'b0000 → done at t+1; en never high.
- Mid-scan reset and stray start: asserting rst_n=0 during DWELL immediately gives all outputs 0; start pulses during DWELL are ignored, so the scan length is unchanged.
- Data path: toggling data_in every cycle in DWELL → in equals data_in delayed by one cycle throughout.
